// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a shared single-port RAM with a
// registered-read latency of one cycle; each transaction takes four cycles.
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
    typedef enum logic {PORT_A, PORT_B} port_t;

    state_t state, state_nxt;
    port_t  owner, last_owner, winner;
    logic   any_req;
    logic   op_we;

    // Contention goes to whichever port did not win last time.
    always_comb begin
        winner  = PORT_A;
        any_req = a_req | b_req;
        if (a_req && b_req)
            winner = (last_owner == PORT_A) ? PORT_B : PORT_A;
        else if (b_req)
            winner = PORT_B;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        a_ack     = 1'b0;
        b_ack     = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (any_req)
                    state_nxt = ISSUE;
            end
            ISSUE: state_nxt = WAIT;
            WAIT:  state_nxt = ACK;
            ACK: begin
                state_nxt = IDLE;
                a_ack     = (owner == PORT_A);
                b_ack     = (owner == PORT_B);
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_we     <= 1'b0;
            op_we      <= 1'b0;
            owner      <= PORT_A;
            last_owner <= PORT_B;
            a_rdata    <= '0;
            b_rdata    <= '0;
        end else begin
            // The write strobe lives for the ISSUE cycle only.
            ram_we <= 1'b0;
            if (state == IDLE && any_req) begin
                owner      <= winner;
                last_owner <= winner;
                if (winner == PORT_B) begin
                    ram_addr  <= b_addr;
                    ram_wdata <= b_wdata;
                    ram_we    <= b_we;
                    op_we     <= b_we;
                end else begin
                    ram_addr  <= a_addr;
                    ram_wdata <= a_wdata;
                    ram_we    <= a_we;
                    op_we     <= a_we;
                end
            end
            if (state == WAIT && !op_we) begin
                if (owner == PORT_B)
                    b_rdata <= ram_rdata;
                else
                    a_rdata <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, contention and
// reset-abort sequences, then random traffic against a transaction-level model.
module tb_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_req, a_we, a_ack;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_req, b_we, b_ack;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic          ram_we, busy;

    logic          mem_load = 1'b0;
    logic [DW-1:0] ram [256];
    logic [DW-1:0] ref_mem [256];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        bit            pb;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] own_rd;
        logic [DW-1:0] oth_rd;
        bit            gap4;
    } vec_t;

    vec_t tbl [8];

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input int unsigned i);
        logic [7:0] b;
        b = i[7:0];
        if (b == 8'h2E) return 16'hAAAA;
        if (b == 8'h2F) return 16'h5555;
        return {b, ~b};
    endfunction

    // Single-port RAM with one-cycle registered read.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int unsigned i = 0; i < 256; i++) ram[i] <= pat(i);
        end else if (ram_we) begin
            ram[ram_addr] <= ram_wdata;
        end
        ram_rdata <= ram[ram_addr];
    end

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input bit pb, input logic req, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        if (pb) begin
            b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
        end else begin
            a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
        end
    endtask

    task automatic do_reset(input bit load);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        mem_load = load;
        tick();
        tick();
        mem_load = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic new_txn(input bit pb);
        drive(pb, 1'b1, 1'($urandom_range(1, 0)), AW'($urandom_range(31, 0)), DW'($urandom));
    endtask

    // One transaction from an idle interval; returns in the following IDLE interval.
    task automatic run_single(input vec_t v, output int ack_at);
        logic          own_ack, oth_ack;
        logic [DW-1:0] own_rd, oth_rd;
        ack_at = -1;
        drive(v.pb, 1'b1, v.we, v.addr, v.wdata);
        for (int k = 1; k <= 4; k++) begin
            tick();
            own_ack = v.pb ? b_ack : a_ack;
            oth_ack = v.pb ? a_ack : b_ack;
            own_rd  = v.pb ? b_rdata : a_rdata;
            oth_rd  = v.pb ? a_rdata : b_rdata;
            if (k == 1) begin
                check1("issue_we", ram_we, v.we);
                checkw("issue_addr", 32'(ram_addr), 32'(v.addr));
                if (v.we) checkw("issue_wdata", 32'(ram_wdata), 32'(v.wdata));
                drive(v.pb, 1'b1, ~v.we, AW'($urandom), DW'($urandom));
            end else begin
                check1("we_low", ram_we, 1'b0);
                checkw("hold_addr", 32'(ram_addr), 32'(v.addr));
            end
            check1("busy", busy, k != 4);
            check1("own_ack", own_ack, k == 3);
            check1("other_ack", oth_ack, 1'b0);
            if (k >= 3) begin
                checkw("own_rdata", 32'(own_rd), 32'(v.own_rd));
                checkw("other_rdata", 32'(oth_rd), 32'(v.oth_rd));
            end
            if (k == 3) begin
                ack_at = cyc;
                drive(v.pb, 1'b0, 1'b0, '0, '0);
            end
        end
    endtask

    initial begin
        int            ack_at, prev_ack, j;
        logic          exp_a, exp_b;
        int            ack_c, grant_c, nxt_free;
        bit            last_b, own_b;
        logic          t_we;
        logic [AW-1:0] t_addr;
        logic [DW-1:0] t_rd, t_wd, exp_ard, exp_brd;

        tbl[0] = '{1'b0, 1'b0, 8'h2E, 16'h0000, 16'hAAAA, 16'h0000, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 8'h30, 16'h7FF8, 16'hAAAA, 16'h0000, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 8'h30, 16'h0000, 16'h7FF8, 16'h0000, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 8'h2F, 16'h0000, 16'h5555, 16'h7FF8, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 8'h2F, 16'h0000, 16'h5555, 16'h7FF8, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 8'h2F, 16'h0000, 16'h5555, 16'h7FF8, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 8'h2E, 16'h1234, 16'h5555, 16'h7FF8, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 8'h2E, 16'h0000, 16'h1234, 16'h5555, 1'b1};

        // Reset with random inputs, checked before the first clock edge.
        rst_n = 1'b0;
        drive(1'b0, 1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom));
        drive(1'b1, 1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom));
        #2;
        check1("rst_a_ack", a_ack, 1'b0);
        check1("rst_b_ack", b_ack, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_ram_we", ram_we, 1'b0);
        checkw("rst_ram_addr", 32'(ram_addr), 32'd0);
        checkw("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        checkw("rst_a_rdata", 32'(a_rdata), 32'd0);
        checkw("rst_b_rdata", 32'(b_rdata), 32'd0);

        // Directed vector table.
        do_reset(1'b1);
        prev_ack = 0;
        for (int i = 0; i < 8; i++) begin
            run_single(tbl[i], ack_at);
            if (tbl[i].gap4) checkw("ack_gap", 32'(ack_at - prev_ack), 32'd4);
            prev_ack = ack_at;
        end

        // Both ports held: A,B,A,B with acks every 4 cycles.
        do_reset(1'b1);
        drive(1'b0, 1'b1, 1'b0, 8'h10, '0);
        drive(1'b1, 1'b1, 1'b0, 8'h11, '0);
        for (int i = 0; i < 16; i++) begin
            tick();
            j = i + 1;
            exp_a = (j % 4 == 3) && ((j / 4) % 2 == 0);
            exp_b = (j % 4 == 3) && ((j / 4) % 2 == 1);
            check1("rr_a_ack", a_ack, exp_a);
            check1("rr_b_ack", b_ack, exp_b);
            check1("rr_both_ack", a_ack & b_ack, 1'b0);
            if (exp_a) checkw("rr_a_rdata", 32'(a_rdata), 32'h10EF);
            if (exp_b) checkw("rr_b_rdata", 32'(b_rdata), 32'h11EE);
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);

        // Reset pulse during a B write's ISSUE cycle.
        do_reset(1'b1);
        drive(1'b1, 1'b1, 1'b1, 8'h31, 16'h001F);
        tick();
        check1("abort_we_issue", ram_we, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 8'h31, '0);
        #1 rst_n = 1'b0;
        #1;
        check1("abort_we_async", ram_we, 1'b0);
        check1("abort_busy", busy, 1'b0);
        check1("abort_b_ack", b_ack, 1'b0);
        #1 rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check1("post_abort_b_ack", b_ack, 1'b0);
            check1("post_abort_a_ack", a_ack, i == 3);
            check1("post_abort_busy", busy, i < 4);
            if (i == 3) begin
                checkw("post_abort_a_rdata", 32'(a_rdata), 32'h31CE);
                drive(1'b0, 1'b0, 1'b0, '0, '0);
                drive(1'b1, 1'b0, 1'b0, '0, '0);
            end
        end
        checkw("abort_no_write", 32'(ram[8'h31]), 32'h31CE);

        // Random traffic against a transaction-level model.
        do_reset(1'b1);
        for (int unsigned i = 0; i < 256; i++) ref_mem[i] = pat(i);
        ack_c = -100; grant_c = -100; nxt_free = 0;
        last_b = 1'b1; own_b = 1'b0; t_we = 1'b0; t_addr = '0; t_rd = '0;
        exp_ard = '0; exp_brd = '0;
        for (int c = 0; c < 1500; c++) begin
            if (c != 0) tick();
            check1("rnd_busy", busy, (c > grant_c) && (c <= ack_c));
            check1("rnd_a_ack", a_ack, (c == ack_c) && !own_b);
            check1("rnd_b_ack", b_ack, (c == ack_c) && own_b);
            check1("rnd_ram_we", ram_we, (c == grant_c + 1) && t_we);
            if (c == grant_c + 1) checkw("rnd_ram_addr", 32'(ram_addr), 32'(t_addr));
            if (c == ack_c && !t_we) begin
                if (own_b) exp_brd = t_rd;
                else       exp_ard = t_rd;
            end
            checkw("rnd_a_rdata", 32'(a_rdata), 32'(exp_ard));
            checkw("rnd_b_rdata", 32'(b_rdata), 32'(exp_brd));

            if (c == ack_c) begin
                if ($urandom_range(1, 0) == 1) new_txn(own_b);
                else drive(own_b, 1'b0, 1'b0, '0, '0);
            end else if (c > grant_c && c < ack_c && $urandom_range(3, 0) == 0) begin
                drive(own_b, 1'b1, 1'($urandom), AW'($urandom), DW'($urandom));
            end
            if (!a_req && $urandom_range(2, 0) == 0) new_txn(1'b0);
            if (!b_req && $urandom_range(2, 0) == 0) new_txn(1'b1);

            if (c >= nxt_free && (a_req || b_req)) begin
                own_b  = b_req && (!a_req || !last_b);
                last_b = own_b;
                t_we   = own_b ? b_we : a_we;
                t_addr = own_b ? b_addr : a_addr;
                t_wd   = own_b ? b_wdata : a_wdata;
                if (t_we) ref_mem[t_addr] = t_wd;
                else      t_rd = ref_mem[t_addr];
                grant_c  = c;
                ack_c    = c + 3;
                nxt_free = c + 4;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 8, meaning RAM word-address width.
REQ-002 The module SHALL have parameter DATA_W, default 16, meaning RAM data width.
REQ-003 The module SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_req  in  1  port A (CPU) request, held until a_ack.
- a_we  in  1  port A write enable (1 = STR, 0 = fetch/LDR).
- a_addr  in  ADDR_W  port A word address.
- a_wdata  in  DATA_W  port A write data.
- a_ack  out  1  port A one-cycle completion pulse.
- a_rdata  out  DATA_W  port A read data, registered.
- b_req  in  1  port B (loader/DMA) request, held until b_ack.
- b_we  in  1  port B write enable.
- b_addr  in  ADDR_W  port B word address.
- b_wdata  in  DATA_W  port B write data.
- b_ack  out  1  port B one-cycle completion pulse.
- b_rdata  out  DATA_W  port B read data, registered.
- ram_addr  out  ADDR_W  shared single-port RAM address, registered.
- ram_wdata  out  DATA_W  RAM write data, registered.
- ram_we  out  1  RAM write strobe, registered.
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_addr is presented.
- busy  out  1  high whenever state != IDLE.

Function
REQ-004 The FSM SHALL have states IDLE, ISSUE, WAIT, ACK, with registered state.
REQ-005 In IDLE with no request, the FSM SHALL stay in IDLE.
- Any request -> ISSUE.
- ISSUE -> WAIT -> ACK -> IDLE unconditionally.
REQ-006 At the IDLE->ISSUE edge, the winner's addr, wdata and we SHALL be captured into ram_addr, ram_wdata, ram_we and the owner register.
- Later changes on the requester's inputs SHALL be ignored until ACK.
REQ-007 ram_we SHALL be high only during ISSUE, and only for a write.
- ram_we SHALL be 0 in all other states.
- ram_addr and ram_wdata SHALL hold their values through ISSUE, WAIT and ACK.
REQ-008 On a read, ram_rdata during WAIT SHALL be loaded into the owner's rdata register at the WAIT->ACK edge.
- The other port's rdata SHALL be unchanged.
- On a write, neither rdata register SHALL change.
REQ-009 The owner's ack SHALL be high for exactly the ACK cycle; the other ack SHALL be 0.
- Latency: request sampled in IDLE cycle 0 -> ack in cycle 3.
- Throughput: one transaction per 4 cycles.
REQ-010 Requester protocol:
- Deassert req, or present a new request, at the edge that samples ack.
- A req still high in the following IDLE SHALL be treated as a new transaction.
REQ-011 Arbitration SHALL be round-robin via a last_owner register.
- Only one req high: that port wins.
- Both high: the port != last_owner wins.
- last_owner SHALL update at the IDLE->ISSUE edge.
REQ-012 A request arriving while busy SHALL wait; it SHALL NOT be dropped or preempt the current transaction.
REQ-013 rdata registers SHALL hold their last value indefinitely, including across later writes by either port.

Reset
REQ-014 rst_n low SHALL immediately, without a clock, force:
- state IDLE; ram_we, a_ack, b_ack, busy = 0.
- ram_addr, ram_wdata, a_rdata, b_rdata = 0.
- last_owner = B, so A wins the first contention.
REQ-015 Reset asserted mid-transaction SHALL abort it: no ack is issued, and a write whose ISSUE edge has not occurred is not performed.
REQ-016 After rst_n rises, the first IDLE cycle SHALL sample requests normally.

Verification
REQ-017 Reset with all inputs random -> all outputs 0, busy 0, before any clock edge.
REQ-018 RAM[0x2E]=16'hAAAA; A read 0x2E -> ISSUE/WAIT/ACK in cycles 1/2/3, a_ack in cycle 3 only, a_rdata=16'hAAAA, ram_we never high, b_rdata unchanged.
REQ-019 A write 0x30 <= 16'h7FF8, then A read 0x30 -> ram_we high exactly one cycle, ram_addr=0x30; read returns 16'h7FF8.
REQ-020 a_req and b_req held continuously after reset, each re-requesting after ack -> grant order A,B,A,B; each ack spaced 4 cycles apart; no cycle with both acks.
REQ-021 b_req only, 3 back-to-back reads of 0x2F (RAM=16'h5555) -> three b_ack pulses 4 cycles apart, b_rdata=16'h5555, a_ack never high.
REQ-022 B write 0x31 <= 16'h001F; rst_n pulsed low during ISSUE -> ram_we falls asynchronously, RAM[0x31] unchanged, no b_ack, busy 0, next request granted to A if both pending.
